// File: rtl/tlut_acc_pkg.sv
// Shared types and width helpers for the TLUT tile accumulator.
package tlut_acc_pkg;

    localparam int DEF_DIM_MULT  = 9;
    localparam int DEF_ACC_WIDTH = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } acc_state_t;

    // Width that holds tiles x (2^acc_w - 1) without wrapping.
    function automatic int acc_width(input int acc_w, input int tiles);
        return acc_w + $clog2(tiles);
    endfunction

endpackage

// File: rtl/tile_accumulator.sv
// Sums NUM_TILES partial-product vectors per element, then streams the
// finished vector out one element per cycle over a valid/ready interface.
module tile_accumulator
    import tlut_acc_pkg::*;
#(
    parameter int DIM_MULT  = DEF_DIM_MULT,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int NUM_TILES = 4,
    parameter int OUT_WIDTH = acc_width(ACC_WIDTH, NUM_TILES),
    parameter int IDX_WIDTH = $clog2(DIM_MULT)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DIM_MULT-1:0][ACC_WIDTH-1:0] in_mult,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OUT_WIDTH-1:0]               out_data,
    output logic [IDX_WIDTH-1:0]               out_idx,
    output logic                               out_last
);

    localparam int CNT_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam logic [CNT_W-1:0]     LAST_TILE = CNT_W'(NUM_TILES - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(DIM_MULT - 1);

    acc_state_t           state_r;
    acc_state_t           state_nxt_s;
    logic [CNT_W-1:0]     tile_cnt_r;
    logic [CNT_W-1:0]     tile_cnt_nxt_s;
    logic [IDX_WIDTH-1:0] drain_idx_r;
    logic [IDX_WIDTH-1:0] drain_idx_nxt_s;
    logic [OUT_WIDTH-1:0] acc_r     [DIM_MULT];
    logic [OUT_WIDTH-1:0] acc_nxt_s [DIM_MULT];
    logic                 accept_s;
    logic                 first_tile_s;
    logic                 out_valid_r;
    logic                 out_last_r;
    logic [OUT_WIDTH-1:0] out_data_r;
    logic [IDX_WIDTH-1:0] out_idx_r;

    // in_ready must drop in any reset cycle, so it is qualified with rst directly.
    assign in_ready     = (state_r == ACCUM) && !rst;
    assign accept_s     = in_valid && in_ready;
    assign first_tile_s = (tile_cnt_r == {CNT_W{1'b0}});

    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;

    for (genvar g = 0; g < DIM_MULT; g++) begin : g_lane
        logic [OUT_WIDTH-1:0] ext_s;

        assign ext_s = OUT_WIDTH'(in_mult[g]);
        // The first tile overwrites, so no clear cycle is needed between results.
        assign acc_nxt_s[g] = !accept_s    ? acc_r[g] :
                              first_tile_s ? ext_s    :
                                             acc_r[g] + ext_s;

        // Per-element accumulator register.
        always_ff @(posedge clk) begin
            if (rst) begin
                acc_r[g] <= {OUT_WIDTH{1'b0}};
            end else begin
                acc_r[g] <= acc_nxt_s[g];
            end
        end
    end

    // Next-state logic for the accumulate / drain sequencing.
    always_comb begin
        state_nxt_s     = state_r;
        tile_cnt_nxt_s  = tile_cnt_r;
        drain_idx_nxt_s = drain_idx_r;
        case (state_r)
            ACCUM: begin
                if (accept_s) begin
                    if (tile_cnt_r == LAST_TILE) begin
                        state_nxt_s     = DRAIN;
                        tile_cnt_nxt_s  = {CNT_W{1'b0}};
                        drain_idx_nxt_s = {IDX_WIDTH{1'b0}};
                    end else begin
                        tile_cnt_nxt_s  = tile_cnt_r + CNT_W'(1);
                    end
                end else begin
                    tile_cnt_nxt_s = tile_cnt_r;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (drain_idx_r == LAST_IDX) begin
                        state_nxt_s     = ACCUM;
                        drain_idx_nxt_s = {IDX_WIDTH{1'b0}};
                    end else begin
                        drain_idx_nxt_s = drain_idx_r + IDX_WIDTH'(1);
                    end
                end else begin
                    drain_idx_nxt_s = drain_idx_r;
                end
            end
            default: begin
                state_nxt_s     = ACCUM;
                tile_cnt_nxt_s  = {CNT_W{1'b0}};
                drain_idx_nxt_s = {IDX_WIDTH{1'b0}};
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ACCUM;
            tile_cnt_r  <= {CNT_W{1'b0}};
            drain_idx_r <= {IDX_WIDTH{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            tile_cnt_r  <= tile_cnt_nxt_s;
            drain_idx_r <= drain_idx_nxt_s;
        end
    end

    // Outputs are registered from next-state values so element 0 is visible
    // in the first drain cycle without a combinational path from in_mult.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_idx_r   <= {IDX_WIDTH{1'b0}};
            out_data_r  <= {OUT_WIDTH{1'b0}};
        end else begin
            out_valid_r <= (state_nxt_s == DRAIN);
            out_last_r  <= (state_nxt_s == DRAIN) && (drain_idx_nxt_s == LAST_IDX);
            out_idx_r   <= drain_idx_nxt_s;
            out_data_r  <= (state_nxt_s == DRAIN) ? acc_nxt_s[drain_idx_nxt_s]
                                                  : {OUT_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_tile_accumulator.sv
// Self-checking bench for tile_accumulator: queue-based cycle model plus
// directed vector table, reset corner cases, random traffic and a 1-tile build.
module tb_tile_accumulator;

    localparam int DIM = 9;
    localparam int AW  = 16;
    localparam int NT  = 4;
    localparam int OW  = 18;
    localparam int IW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [DIM-1:0][AW-1:0] in_mult;
    logic [OW-1:0]          out_data;
    logic [IW-1:0]          out_idx;

    logic                   in_valid1, in_ready1, out_valid1, out_ready1, out_last1;
    logic [DIM-1:0][AW-1:0] in_mult1;
    logic [AW-1:0]          out_data1;
    logic [IW-1:0]          out_idx1;

    tile_accumulator #(.NUM_TILES(NT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mult(in_mult), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
    );

    tile_accumulator #(.NUM_TILES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_mult(in_mult1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .out_idx(out_idx1), .out_last(out_last1)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: running sums and a queue of finished elements awaiting drain.
    typedef struct {
        int unsigned data;
        int          idx;
        bit          last;
    } elem_t;

    elem_t       outq[$];
    int unsigned sums[DIM];
    int          ntiles   = 0;
    bit          model_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            outq.delete();
            ntiles   = 0;
            model_on = 1'b1;
        end else if (model_on) begin
            if (outq.size() == 0) begin
                if (in_valid) begin
                    for (int i = 0; i < DIM; i++)
                        sums[i] = ((ntiles == 0) ? 32'd0 : sums[i]) + 32'(in_mult[i]);
                    ntiles++;
                    if (ntiles == NT) begin
                        for (int i = 0; i < DIM; i++) outq.push_back('{sums[i], i, (i == DIM - 1)});
                        ntiles = 0;
                    end
                end
            end else if (out_ready) begin
                void'(outq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("in_ready", 32'(in_ready), 32'(!rst && (outq.size() == 0)));
            if (outq.size() > 0) begin
                chk("out_valid", 32'(out_valid), 32'd1);
                chk("out_data",  32'(out_data),  outq[0].data);
                chk("out_idx",   32'(out_idx),   32'(outq[0].idx));
                chk("out_last",  32'(out_last),  32'(outq[0].last));
            end else begin
                chk("out_valid_idle", 32'(out_valid), 32'd0);
            end
        end
    end

    logic [OW-1:0] cap_data [DIM];
    int            cap_idx  [DIM];
    bit            cap_last [DIM];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int mul, input int add, input int tiles, input int gap);
        for (int t = 0; t < tiles; t++) begin
            int budget = 50;
            bit got    = 1'b0;
            in_valid = 1'b1;
            for (int i = 0; i < DIM; i++) in_mult[i] = AW'(mul * (i + 1) + add);
            while (!got && budget > 0) begin
                @(negedge clk);
                got = in_ready;
                tick();
                budget--;
            end
            if (!got) chk("feed_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            for (int i = 0; i < DIM; i++) in_mult[i] = AW'($urandom);
            repeat (gap) tick();
        end
    endtask

    task automatic collect(input int mode, input bit junk_valid, output int n);
        int cyc = 0;
        n = 0;
        while (n < DIM && cyc < 100) begin
            out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            in_valid  = junk_valid;
            for (int i = 0; i < DIM; i++) in_mult[i] = AW'($urandom);
            @(negedge clk);
            if (out_valid && out_ready) begin
                cap_data[n] = out_data;
                cap_idx[n]  = 32'(out_idx);
                cap_last[n] = out_last;
                n++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (n < DIM) chk("collect_timeout", 32'(n), 32'(DIM));
    endtask

    typedef struct {
        int            mul;
        int            add;
        int            mode;
        bit            junk;
        int            gap;
        logic [OW-1:0] exp0;
        logic [OW-1:0] exp8;
    } vec_t;

    initial begin
        vec_t                   tbl[5];
        int                     n;
        logic [DIM-1:0][AW-1:0] v;

        tbl[0] = '{1,      0,           0, 1'b0, 0, 18'd4,      18'd36};
        tbl[1] = '{0,      32'hFFFF,    0, 1'b0, 0, 18'h3FFFC,  18'h3FFFC};
        tbl[2] = '{2,      3,           1, 1'b1, 0, 18'd20,     18'd84};
        tbl[3] = '{100,    5,           0, 1'b0, 2, 18'd420,    18'd3620};
        tbl[4] = '{0,      0,           1, 1'b0, 1, 18'd0,      18'd0};

        rst = 1'b1; in_valid = 1'b0; in_mult = '0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_mult1 = '0; out_ready1 = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_idx",   32'(out_idx),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        tick();
        rst = 1'b0;

        for (int r = 0; r < 5; r++) begin
            feed(tbl[r].mul, tbl[r].add, NT, tbl[r].gap);
            collect(tbl[r].mode, tbl[r].junk, n);
            chk("tbl_elem0", 32'(cap_data[0]), 32'(tbl[r].exp0));
            chk("tbl_elem8", 32'(cap_data[DIM-1]), 32'(tbl[r].exp8));
            for (int k = 0; k < DIM; k++) begin
                chk("tbl_data", 32'(cap_data[k]), 32'(NT * ((tbl[r].mul * (k + 1) + tbl[r].add) & 32'hFFFF)));
                chk("tbl_idx",  32'(cap_idx[k]),  32'(k));
                chk("tbl_last", 32'(cap_last[k]), 32'(k == DIM - 1));
            end
        end

        // Reset after two tiles: stale partial sums must not leak into the next result.
        feed(5, 7, 2, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        feed(0, 1, NT, 0);
        collect(0, 1'b0, n);
        for (int k = 0; k < DIM; k++) chk("rst_accum_data", 32'(cap_data[k]), 32'd4);

        // Reset while element 3 is on the output.
        feed(3, 1, NT, 0);
        out_ready = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_drain_idx",   32'(out_idx),   32'd3);
        chk("rst_drain_valid", 32'(out_valid), 32'd1);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("rst_drain_quiet", 32'(out_valid), 32'd0);
            tick();
        end
        out_ready = 1'b0;

        // Random traffic, checked cycle by cycle by the model.
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < DIM; i++) in_mult[i] = AW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();

        // Single-tile build: each vector drains unchanged, index 0 the cycle after accept.
        out_ready1 = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DIM; i++) v[i] = AW'($urandom);
            in_mult1  = v;
            in_valid1 = 1'b1;
            @(negedge clk);
            chk("t1_in_ready", 32'(in_ready1), 32'd1);
            tick();
            in_valid1 = 1'b0;
            for (int k = 0; k < DIM; k++) begin
                @(negedge clk);
                chk("t1_valid", 32'(out_valid1), 32'd1);
                chk("t1_idx",   32'(out_idx1),   32'(k));
                chk("t1_data",  32'(out_data1),  32'(v[k]));
                chk("t1_last",  32'(out_last1),  32'(k == DIM - 1));
                tick();
            end
            @(negedge clk);
            chk("t1_idle_valid", 32'(out_valid1), 32'd0);
            chk("t1_idle_ready", 32'(in_ready1),  32'd1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
